// File: rtl/id_exe_skid_reg_pkg.sv
// Shared ID/EXE pipeline types: skid state encoding,
// default datapath widths and the control-field bundle.
package id_exe_skid_reg_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CMD_W_DEF  = 4;
  localparam int SHIFT_W    = 12;
  localparam int DEST_W     = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

  typedef struct packed {
    logic [SHIFT_W-1:0] shiftOperand;
    logic               imm;
    logic               isMem;
    logic               memRead;
    logic               memWrite;
    logic               wbEn;
    logic               sBit;
    logic [DEST_W-1:0]  dest;
  } ctrl_t;

endpackage

// File: rtl/id_exe_skid_reg_entry.sv
// Enable-loaded bundle register with async active-low clear.
// Used for both the head and the skid slot.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_exe_skid_reg.sv
// Two-entry ID/EXE skid buffer: head drives EXE, skid absorbs
// one extra instruction so inReady can be a pure register.
module id_exe_skid_reg
  import id_exe_skid_reg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CMD_W  = CMD_W_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WORD_W-1:0] inPc,
  input  logic [WORD_W-1:0] inValRn,
  input  logic [WORD_W-1:0] inValRm,
  input  logic [11:0]       inShiftOperand,
  input  logic              inImm,
  input  logic              inIsMem,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inWbEn,
  input  logic              inSBit,
  input  logic [CMD_W-1:0]  inExeCmd,
  input  logic [3:0]        inDest,
  output logic              outValid,
  input  logic              outReady,
  output logic [WORD_W-1:0] outPc,
  output logic [WORD_W-1:0] outValRn,
  output logic [WORD_W-1:0] outValRm,
  output logic [11:0]       outShiftOperand,
  output logic              outImm,
  output logic              outIsMem,
  output logic              outMemRead,
  output logic              outMemWrite,
  output logic              outWbEn,
  output logic              outSBit,
  output logic [CMD_W-1:0]  outExeCmd,
  output logic [3:0]        outDest
);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] valRn;
    logic [WORD_W-1:0] valRm;
    logic [CMD_W-1:0]  exeCmd;
    ctrl_t             ctrl;
  } payload_t;

  localparam int PW = $bits(payload_t);

  skid_st_e r_st;
  skid_st_e w_stNext;
  logic     r_inReady;
  logic     w_accept;
  logic     w_consume;
  logic     w_headEn;
  logic     w_skidEn;
  logic     w_headFromSkid;
  payload_t w_in;
  payload_t w_headD;
  payload_t w_head;
  payload_t w_skid;

  assign w_in.pc                = inPc;
  assign w_in.valRn             = inValRn;
  assign w_in.valRm             = inValRm;
  assign w_in.exeCmd            = inExeCmd;
  assign w_in.ctrl.shiftOperand = inShiftOperand;
  assign w_in.ctrl.imm          = inImm;
  assign w_in.ctrl.isMem        = inIsMem;
  assign w_in.ctrl.memRead      = inMemRead;
  assign w_in.ctrl.memWrite     = inMemWrite;
  assign w_in.ctrl.wbEn         = inWbEn;
  assign w_in.ctrl.sBit         = inSBit;
  assign w_in.ctrl.dest         = inDest;

  assign w_accept  = inValid & r_inReady;
  assign w_consume = outValid & outReady;

  // inReady is registered so outReady never reaches it combinationally.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_st      <= ST_EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_st      <= w_stNext;
      r_inReady <= (w_stNext != ST_FULL);
    end
  end

  // Flush only drops state; payload registers keep stale contents.
  always_comb begin
    w_stNext       = r_st;
    w_headEn       = 1'b0;
    w_skidEn       = 1'b0;
    w_headFromSkid = 1'b0;
    if (flush) begin
      w_stNext = ST_EMPTY;
    end else begin
      unique case (r_st)
        ST_EMPTY: begin
          if (w_accept) begin
            w_headEn = 1'b1;
            w_stNext = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_consume) begin
            w_skidEn = 1'b1;
            w_stNext = ST_FULL;
          end else if (w_accept) begin
            w_headEn = 1'b1;
          end else if (w_consume) begin
            w_stNext = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_headEn       = 1'b1;
            w_headFromSkid = 1'b1;
            w_stNext       = ST_ONE;
          end
        end
        default: w_stNext = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    outValid = (r_st != ST_EMPTY);
    inReady  = r_inReady;
  end

  assign w_headD = w_headFromSkid ? w_skid : w_in;

  pipe_entry_reg #(.W(PW)) u_head (
    .clk  (clk),
    .rstN (rstN),
    .i_en (w_headEn),
    .i_d  (w_headD),
    .o_q  (w_head)
  );

  pipe_entry_reg #(.W(PW)) u_skid (
    .clk  (clk),
    .rstN (rstN),
    .i_en (w_skidEn),
    .i_d  (w_in),
    .o_q  (w_skid)
  );

  assign outPc           = w_head.pc;
  assign outValRn        = w_head.valRn;
  assign outValRm        = w_head.valRm;
  assign outExeCmd       = w_head.exeCmd;
  assign outShiftOperand = w_head.ctrl.shiftOperand;
  assign outImm          = w_head.ctrl.imm;
  assign outIsMem        = w_head.ctrl.isMem;
  assign outMemRead      = w_head.ctrl.memRead;
  assign outMemWrite     = w_head.ctrl.memWrite;
  assign outWbEn         = w_head.ctrl.wbEn;
  assign outSBit         = w_head.ctrl.sBit;
  assign outDest         = w_head.ctrl.dest;

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Self-checking bench for id_exe_skid_reg: directed scenarios
// plus a random run against a queue reference model.
module tb_id_exe_skid_reg;

  localparam int BW = 122;
  typedef logic [BW-1:0] bus_t;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inPc, inValRn, inValRm;
  logic [11:0] inShiftOperand;
  logic        inImm, inIsMem, inMemRead, inMemWrite, inWbEn, inSBit;
  logic [3:0]  inExeCmd;
  logic [3:0]  inDest;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc, outValRn, outValRm;
  logic [11:0] outShiftOperand;
  logic        outImm, outIsMem, outMemRead, outMemWrite, outWbEn, outSBit;
  logic [3:0]  outExeCmd;
  logic [3:0]  outDest;

  int total;
  int bad;

  id_exe_skid_reg dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .inPc(inPc), .inValRn(inValRn), .inValRm(inValRm),
    .inShiftOperand(inShiftOperand), .inImm(inImm),
    .inIsMem(inIsMem), .inMemRead(inMemRead),
    .inMemWrite(inMemWrite), .inWbEn(inWbEn), .inSBit(inSBit),
    .inExeCmd(inExeCmd), .inDest(inDest),
    .outValid(outValid), .outReady(outReady),
    .outPc(outPc), .outValRn(outValRn), .outValRm(outValRm),
    .outShiftOperand(outShiftOperand), .outImm(outImm),
    .outIsMem(outIsMem), .outMemRead(outMemRead),
    .outMemWrite(outMemWrite), .outWbEn(outWbEn), .outSBit(outSBit),
    .outExeCmd(outExeCmd), .outDest(outDest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input bus_t b);
    {inPc, inValRn, inValRm, inExeCmd, inShiftOperand, inImm, inIsMem,
     inMemRead, inMemWrite, inWbEn, inSBit, inDest} = b;
  endtask

  function automatic bus_t out_bus();
    return {outPc, outValRn, outValRm, outExeCmd, outShiftOperand,
            outImm, outIsMem, outMemRead, outMemWrite, outWbEn,
            outSBit, outDest};
  endfunction

  function automatic bus_t rand_bus();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[BW-1:0];
  endfunction

  task automatic set_pc(input logic [31:0] pc);
    set_in(rand_bus());
    inPc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    set_in('0);
    #12;
    total++;
    if (outValid !== 1'b0) begin
      bad++; $display("FAIL reset_outValid got=%b want=0", outValid);
    end
    total++;
    if (inReady !== 1'b1) begin
      bad++; $display("FAIL reset_inReady got=%b want=1", inReady);
    end
    total++;
    if (out_bus() !== '0) begin
      bad++; $display("FAIL reset_payload got=%h want=0", out_bus());
    end
    @(negedge clk);
    rstN = 1'b1;
    step();
  endtask

  task automatic test_payload();
    bus_t exp;
    set_in(rand_bus());
    inShiftOperand = 12'h3FF; inImm = 1'b1;
    inExeCmd = 4'h9; inDest = 4'hE;
    exp = {inPc, inValRn, inValRm, inExeCmd, inShiftOperand, inImm,
           inIsMem, inMemRead, inMemWrite, inWbEn, inSBit, inDest};
    inValid = 1'b1; outReady = 1'b0;
    step();
    inValid = 1'b0;
    total++;
    if (outValid !== 1'b1 || out_bus() !== exp) begin
      bad++;
      $display("FAIL payload valid=%b got=%h want=%h", outValid, out_bus(), exp);
    end
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    total++;
    if (outValid !== 1'b0) begin
      bad++; $display("FAIL payload_drain got=%b want=0", outValid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    inValid = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_pc(pcs[i]);
      step();
      total++;
      if (outValid !== 1'b1 || outPc !== pcs[i] || inReady !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d valid=%b rdy=%b pc=%h want=%h",
                 i, outValid, inReady, outPc, pcs[i]);
      end
    end
    inValid = 1'b0;
    step();
    outReady = 1'b0;
    total++;
    if (outValid !== 1'b0) begin
      bad++; $display("FAIL stream_end got=%b want=0", outValid);
    end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0; inValid = 1'b1;
    set_pc(32'h10); step();
    set_pc(32'h14); step();
    inValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (inReady !== 1'b0 || outValid !== 1'b1 || outPc !== 32'h10) begin
        bad++;
        $display("FAIL bp_full_%0d rdy=%b valid=%b pc=%h want rdy=0 pc=10",
                 i, inReady, outValid, outPc);
      end
      step();
    end
    outReady = 1'b1;
    #1;
    total++;
    if (outPc !== 32'h10) begin
      bad++; $display("FAIL bp_head got=%h want=10", outPc);
    end
    step();
    total++;
    if (outValid !== 1'b1 || outPc !== 32'h14 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL bp_second valid=%b pc=%h rdy=%b want pc=14",
               outValid, outPc, inReady);
    end
    step();
    outReady = 1'b0;
    total++;
    if (outValid !== 1'b0) begin
      bad++; $display("FAIL bp_drain got=%b want=0", outValid);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0; inValid = 1'b1;
    set_pc(32'h20); step();
    set_pc(32'h24); step();
    set_pc(32'h28); flush = 1'b1;
    step();
    flush = 1'b0; inValid = 1'b0;
    total++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL flush valid=%b rdy=%b want valid=0 rdy=1", outValid, inReady);
    end
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    total++;
    if (outValid !== 1'b0) begin
      bad++; $display("FAIL flush_no_28 valid=%b pc=%h want valid=0", outValid, outPc);
    end
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0; inValid = 1'b1;
    set_pc(32'h30); step();
    set_pc(32'h34); step();
    inValid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    total++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || out_bus() !== '0) begin
      bad++;
      $display("FAIL reset_mid valid=%b rdy=%b bus=%h want 0/1/0",
               outValid, inReady, out_bus());
    end
    @(negedge clk);
    rstN = 1'b1;
    inValid = 1'b1; set_pc(32'h40);
    step();
    inValid = 1'b0;
    total++;
    if (outValid !== 1'b1 || outPc !== 32'h40 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_after valid=%b pc=%h rdy=%b want pc=40",
               outValid, outPc, inReady);
    end
    outReady = 1'b1; step(); outReady = 1'b0;
  endtask

  task automatic test_random();
    bus_t q[$];
    bus_t cur;
    logic expRdy, expVld, acc, con, rdySave;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 49) == 0);
      cur = rand_bus();
      set_in(cur);
      expRdy = (q.size() < 2);
      expVld = (q.size() > 0);
      total++;
      if (inReady !== expRdy || outValid !== expVld) begin
        bad++;
        $display("FAIL rand_hs cyc=%0d rdy=%b/%b valid=%b/%b",
                 cyc, inReady, expRdy, outValid, expVld);
      end
      if (expVld) begin
        total++;
        if (out_bus() !== q[0]) begin
          bad++;
          $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, out_bus(), q[0]);
        end
      end
      rdySave = inReady;
      outReady = ~outReady;
      #1;
      total++;
      if (inReady !== rdySave) begin
        bad++;
        $display("FAIL rand_comb_path cyc=%0d got=%b want=%b", cyc, inReady, rdySave);
      end
      outReady = ~outReady;
      #1;
      acc = inValid & expRdy;
      con = expVld & outReady;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
      step();
    end
    flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_payload();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
